pe_mem_arbiter: RTL
===================

// Module: pe_mem_arbiter
// PURPOSE
// Shares one port of the PE dual_port_ram among NUM_REQ requesters (0: core_rv32e MMIO, 1: ddma rx, 2: ddma tx).
// Round-robin arbitration with optional burst lock, capped at MAX_BURST consecutive grants.
// Read data returns one cycle after grant, tagged to the granted requester. Sits between the requesters and mem_if_*.MEM.
// PARAMETERS
// MEMORY_WIDTH  32  data width; byte-enable width is MEMORY_WIDTH/8
// ADDR_WIDTH    32  address width
// NUM_REQ       3   number of requesters, 2..8
// MAX_BURST     16  max consecutive locked grants to one requester, 1..255
// PORTS
// clock      in   1                      single clock, all logic on rising edge
// reset      in   1                      asynchronous, active-low
// req_i      in   NUM_REQ                access request per requester
// lock_i     in   NUM_REQ                requester asks to keep ownership next cycle (burst)
// addr_i     in   NUM_REQ*ADDR_WIDTH     per-requester address, packed, requester 0 in LSBs
// wb_i       in   NUM_REQ*MEMORY_WIDTH/8 per-requester byte write enables; 0 = read
// wdata_i    in   NUM_REQ*MEMORY_WIDTH   per-requester write data
// gnt_o      out  NUM_REQ                one-hot grant; access issued this cycle
// rvalid_o   out  NUM_REQ                one-hot: rdata_o valid for that requester
// rdata_o    out  MEMORY_WIDTH           read data, shared by all requesters
// mem_addr_o out  ADDR_WIDTH             to RAM addr_in
// mem_wb_o   out  MEMORY_WIDTH/8         to RAM wb_in
// mem_data_o out  MEMORY_WIDTH           to RAM data_in
// mem_data_i in   MEMORY_WIDTH           from RAM data_out; valid one cycle after address
// BEHAVIOUR
// - Reset (reset=0, async): gnt_o=0, rvalid_o=0, mem_wb_o=0, rdata_o=0, mem_addr_o=0; rr_ptr=0, owner=none, burst_cnt=0.
// - FSM states: ARB (no owner) / LOCKED (owner valid).
// - ARB: gnt_o combinational = first set req_i bit searching from rr_ptr upward, wrapping. No req -> gnt_o=0, mem_wb_o=0.
// - On grant to k: rr_ptr <= (k+1) mod NUM_REQ. If lock_i[k]=1 -> LOCKED, owner=k, burst_cnt=1.
// - LOCKED: gnt_o[owner]=req_i[owner]; all others 0 even if requesting; burst_cnt increments per grant.
// - Exit LOCKED -> ARB on: lock_i[owner]=0 at a grant, req_i[owner]=0, or burst_cnt==MAX_BURST after a grant.
//   Exit takes effect next cycle, where ARB runs from updated rr_ptr.
// - MAX_BURST cap: after the capping grant, one full ARB cycle is mandatory even if the owner still locks.
//   The owner may win again only if no other requester is pending.
// - Mux: mem_addr_o/mem_wb_o/mem_data_o = granted requester's fields; no grant -> mem_wb_o=0, addr/data hold last value.
// - Read return: rvalid_o <= gnt_o & {NUM_REQ{wb_i[granted]==0}} registered; rdata_o = mem_data_i in that cycle.
// - Writes: complete at the grant edge; no rvalid.
// - Latency: request to grant 0 cycles when uncontested; read data 1 cycle after grant.
// - Worst-case wait: (NUM_REQ-1)*MAX_BURST cycles.
// - Requester must hold req/addr/wb/data stable until gnt_o; dropping req before grant is legal (withdrawn).
// - Simultaneous lock release and new request from owner: treated as ARB; rr_ptr already past owner.
// - Reset mid-burst: owner cleared, any pending rvalid dropped, rr_ptr=0.
// - Widths: burst_cnt is $clog2(MAX_BURST+1) bits; rr_ptr is $clog2(NUM_REQ) bits, wraps at NUM_REQ-1 -> 0.
// - Assertions: gnt_o is $onehot0; rvalid_o is $onehot0; no grant to a requester with req_i=0.
// STRUCTURE
// - manycore_pkg: typedef enum {ARB, LOCKED} arb_state_t; localparam requester indices REQ_CPU=0, REQ_DDMA_RX=1, REQ_DDMA_TX=2.
// - Sub-module rr_pick #(N): combinational one-hot round-robin pick from (req, ptr); reusable by the router.
// - Top holds FSM, rr_ptr, burst_cnt, rvalid pipeline register and the address/data mux.
// TESTING
// - Reset: drive req_i=3'b111 with reset=0 -> gnt_o=0, rvalid_o=0; release reset -> first grant gnt_o=3'b001.
// - Round robin: req_i=3'b111 held, lock_i=0 for 6 cycles -> gnt_o sequence 001,010,100,001,010,100.
// - Read return: req 1 reads addr 'h40 holding 'hDEADBEEF -> gnt_o=010 at cycle t; rvalid_o=010, rdata_o='hDEADBEEF at t+1.
// - Burst cap (MAX_BURST=4): req 2 locked, req 0 pending -> gnt_o=100 for 4 cycles, then 001, then 100 again.
// - Write: req 0 writes 'h12345678, wb=4'hF, addr 'h10; read back -> 'h12345678, no rvalid on the write cycle.
// - Reset mid-burst: assert reset at burst_cnt=2 -> outputs 0 immediately; after release, ARB restarts at requester 0.

Source files
------------

// File: rtl/pe_mem_arbiter_pkg.sv
// Shared types and constants for the PE memory-port arbiter.
package pe_mem_arbiter_pkg;

  // ARB: no owner, round-robin pick each cycle. LOCKED: one requester owns the port.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Requester slot assignment on the PE RAM port.
  localparam int REQ_CPU     = 0;
  localparam int REQ_DDMA_RX = 1;
  localparam int REQ_DDMA_TX = 2;

  // Increment an index, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/pe_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first set request
// found searching upward from ptr, wrapping past N-1 back to 0.
module pe_mem_arbiter_rr_pick #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  localparam int SW = PW + 1;

  logic          found;
  logic [SW-1:0] pos;
  logic [PW-1:0] idx;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + SW'(i);
      if (pos >= SW'(N)) pos = pos - SW'(N);
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Arbiter sharing one dual_port_ram port among NUM_REQ requesters.
// Round-robin with optional burst lock capped at MAX_BURST grants; read data
// comes back one cycle after the grant, tagged one-hot to the requester.
module pe_mem_arbiter
  import pe_mem_arbiter_pkg::*;
#(
  parameter int MEMORY_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int NUM_REQ      = 3,
  parameter int MAX_BURST    = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0]                  lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       addr_i,
  input  logic [NUM_REQ*(MEMORY_WIDTH/8)-1:0] wb_i,
  input  logic [NUM_REQ*MEMORY_WIDTH-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [MEMORY_WIDTH-1:0]             rdata_o,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic [MEMORY_WIDTH/8-1:0]           mem_wb_o,
  output logic [MEMORY_WIDTH-1:0]             mem_data_o,
  input  logic [MEMORY_WIDTH-1:0]             mem_data_i
);

  localparam int BW = MEMORY_WIDTH / 8;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t          state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       owner;
  logic [CW-1:0]       burst_cnt;
  logic [CW-1:0]       cnt_next;
  logic [NUM_REQ-1:0]  pick;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [PW-1:0]       gnt_idx;
  logic                any_gnt;
  logic [ADDR_WIDTH-1:0]   addr_hold;
  logic [MEMORY_WIDTH-1:0] data_hold;

  pe_mem_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // Grant: round-robin pick when free, owner-only when locked; forced low in reset.
  always_comb begin
    gnt_o = '0;
    if (reset) begin
      if (state == LOCKED) gnt_o[owner] = req_i[owner];
      else                 gnt_o = pick;
    end
  end

  // Encode the one-hot grant into an index for the field mux.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) gnt_idx = PW'(i);
    end
  end

  assign any_gnt  = |gnt_o;
  assign cnt_next = burst_cnt + CW'(1);

  // Route the granted requester's fields to the RAM; address/data hold when idle.
  always_comb begin
    mem_addr_o = addr_hold;
    mem_data_o = data_hold;
    mem_wb_o   = '0;
    if (any_gnt) begin
      mem_addr_o = addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_data_o = wdata_i[gnt_idx*MEMORY_WIDTH +: MEMORY_WIDTH];
      mem_wb_o   = wb_i[gnt_idx*BW +: BW];
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = (|rvalid_q) ? mem_data_i : '0;

  // Arbitration FSM, round-robin pointer, burst counter and read-return tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rvalid_q  <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      rvalid_q <= (any_gnt && (mem_wb_o == '0)) ? gnt_o : '0;
      if (any_gnt) begin
        addr_hold <= mem_addr_o;
        data_hold <= mem_data_o;
      end
      case (state)
        ARB: begin
          if (any_gnt) begin
            rr_ptr <= PW'(wrap_inc(int'(gnt_idx), NUM_REQ));
            // A cap of one grant never leaves a cycle to hold the lock.
            if (lock_i[gnt_idx] && (MAX_BURST > 1)) begin
              state     <= LOCKED;
              owner     <= gnt_idx;
              burst_cnt <= CW'(1);
            end
          end
        end
        LOCKED: begin
          // rr_ptr already points past the owner, so the release cycle is fair.
          if (!req_i[owner]) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else if (!lock_i[owner] || (cnt_next == CW'(MAX_BURST))) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= cnt_next;
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  a_gnt_onehot:   assert property (@(posedge clock) disable iff (!reset) $onehot0(gnt_o));
  a_rvalid_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(rvalid_o));
  a_gnt_has_req:  assert property (@(posedge clock) disable iff (!reset) ((gnt_o & ~req_i) == '0));

endmodule
